// File: rtl/ch2_tone_gen_pkg.sv
// ch2_tone_gen_pkg
//   Shared APU definitions used by the channel 2 tone core and the reusable
//   length counter: default widths, duty selector encoding and duty patterns.
package ch2_tone_gen_pkg;

  localparam int FREQ_W_DEF = 11;
  localparam int LEN_W_DEF  = 6;

  typedef enum logic [1:0] {
    DUTY_12 = 2'd0,
    DUTY_25 = 2'd1,
    DUTY_50 = 2'd2,
    DUTY_75 = 2'd3
  } duty_sel_e;

  // Bit n of each entry is the wave level at sequencer step n.
  localparam logic [7:0] DUTY_PAT [0:3] = '{
    8'b1000_0000,   // 12.5 %: high on step 7
    8'b1000_0001,   // 25 %  : high on steps 0,7
    8'b1110_0001,   // 50 %  : high on steps 0,5,6,7
    8'b0111_1110    // 75 %  : high on steps 1..6
  };

endpackage

// File: rtl/ch2_tone_gen_if.sv
// ch2_tone_gen_if
//   Connection between the channel 2 register block / frame sequencer
//   (master) and the channel 2 tone core (slave).
//   master drives: tick_freq, tick_len, duty_sel, len_load, len_wr, freq,
//                  trig, len_en, dac_en
//   slave drives : ch2_on, duty_out, duty_step, ch2_ftick
interface ch2_tone_gen_if
  import ch2_tone_gen_pkg::*;
#(
  parameter int FREQ_W = FREQ_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);

  logic              tick_freq;
  logic              tick_len;
  duty_sel_e         duty_sel;
  logic [LEN_W-1:0]  len_load;
  logic              len_wr;
  logic [FREQ_W-1:0] freq;
  logic              trig;
  logic              len_en;
  logic              dac_en;

  logic              ch2_on;
  logic              duty_out;
  logic [2:0]        duty_step;
  logic              ch2_ftick;

  modport master (
    output tick_freq, tick_len, duty_sel, len_load, len_wr, freq, trig,
           len_en, dac_en,
    input  ch2_on, duty_out, duty_step, ch2_ftick
  );

  modport slave (
    input  tick_freq, tick_len, duty_sel, len_load, len_wr, freq, trig,
           len_en, dac_en,
    output ch2_on, duty_out, duty_step, ch2_ftick
  );

endinterface

// File: rtl/apu_len_ctr.sv
// apu_len_ctr
//   Up-counting length counter with expired flag, shared by the APU channels.
//   Ports:
//     clk, napu_reset : clock, synchronous active-low reset
//     load, load_val  : register write strobe and reload value
//     trig            : channel trigger (restarts an expired counter from 0)
//     tick, en        : length clock enable and length enable bit
//     expire          : one-cycle pulse when the counter wraps to 0
module apu_len_ctr
  import ch2_tone_gen_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             napu_reset,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             trig,
  input  logic             tick,
  input  logic             en,
  output logic             expire
);

  logic [LEN_W-1:0] lcnt_q, lcnt_d;
  logic             expired_q, expired_d;

  // Ordering inside one cycle: load beats everything; otherwise the trigger
  // restart is applied first and the tick then counts from the result.
  always_comb begin
    // NOTE: defaults first so every path assigns each output (no latch).
    lcnt_d    = lcnt_q;
    expired_d = expired_q;
    expire    = 1'b0;
    if (load) begin
      lcnt_d    = load_val;
      expired_d = 1'b0;
    end else begin
      if (trig && expired_q) begin
        lcnt_d    = '0;
        expired_d = 1'b0;
      end
      if (tick && en && !expired_d) begin
        if (lcnt_d == '1) begin
          lcnt_d    = '0;
          expired_d = 1'b1;
          expire    = 1'b1;
        end else begin
          lcnt_d = lcnt_d + LEN_W'(1);
        end
      end
    end
  end

  // NOTE: reset is synchronous, so it only takes effect on a clk edge.
  always_ff @(posedge clk) begin
    if (!napu_reset) begin
      // NOTE: state updates use <= so all flops see pre-edge values.
      lcnt_q    <= '0;
      expired_q <= 1'b0;
    end else begin
      lcnt_q    <= lcnt_d;
      expired_q <= expired_d;
    end
  end

endmodule

// File: rtl/ch2_tone_gen.sv
// ch2_tone_gen
//   Channel 2 tone core: frequency timer, 8-step duty sequencer and (when
//   CH2_LENGTH_EN is defined) the length counter. All outputs are registered.
//   Ports:
//     clk        : APU clock
//     napu_reset : synchronous active-low reset
//     bus        : ch2_tone_gen_if.slave (register fields, strobes, status)
//   Build option: CH2_LENGTH_EN adds the length counter; without it the
//   length inputs are ignored and ch2_on drops only on reset or dac_en=0.
module ch2_tone_gen
  import ch2_tone_gen_pkg::*;
#(
  parameter int FREQ_W = FREQ_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic           clk,
  input  logic           napu_reset,
  ch2_tone_gen_if.slave  bus
);

  logic [FREQ_W-1:0] ftmr_q, ftmr_d;
  logic [2:0]        duty_step_q, duty_step_d;
  logic              ch2_on_q, ch2_on_d;
  logic              duty_out_q, duty_out_d;
  logic              ch2_ftick_q, ch2_ftick_d;
  logic              len_expire;

`ifdef CH2_LENGTH_EN
  apu_len_ctr #(.LEN_W(LEN_W)) u_len_ctr (
    .clk        (clk),
    .napu_reset (napu_reset),
    .load       (bus.len_wr),
    .load_val   (bus.len_load),
    .trig       (bus.trig),
    .tick       (bus.tick_len),
    .en         (bus.len_en),
    .expire     (len_expire)
  );
`else
  logic unused_len_inputs;
  assign unused_len_inputs = ^{bus.tick_len, bus.len_wr, bus.len_load, bus.len_en};
  assign len_expire        = 1'b0;
`endif

  always_comb begin
    ftmr_d      = ftmr_q;
    duty_step_d = duty_step_q;
    ch2_ftick_d = 1'b0;
    ch2_on_d    = ch2_on_q;

    // Trigger reloads the timer and swallows a coincident frequency tick.
    // freq is only sampled at reloads, so writes never disturb a period.
    if (bus.trig) begin
      ftmr_d   = bus.freq;
      ch2_on_d = bus.dac_en;
    end else if (bus.tick_freq) begin
      if (ftmr_q == '1) begin
        ftmr_d      = bus.freq;
        ch2_ftick_d = 1'b1;
        duty_step_d = duty_step_q + 3'd1;
      end else begin
        ftmr_d = ftmr_q + FREQ_W'(1);
      end
    end

    // Length expiry and DAC off override the trigger enable.
    if (len_expire) ch2_on_d = 1'b0;
    if (!bus.dac_en) ch2_on_d = 1'b0;

    // Registered from next-state so level, step and enable stay coherent.
    duty_out_d = ch2_on_d & DUTY_PAT[bus.duty_sel][duty_step_d];
  end

  always_ff @(posedge clk) begin
    if (!napu_reset) begin
      ftmr_q      <= '0;
      duty_step_q <= '0;
      ch2_on_q    <= 1'b0;
      duty_out_q  <= 1'b0;
      ch2_ftick_q <= 1'b0;
    end else begin
      ftmr_q      <= ftmr_d;
      duty_step_q <= duty_step_d;
      ch2_on_q    <= ch2_on_d;
      duty_out_q  <= duty_out_d;
      ch2_ftick_q <= ch2_ftick_d;
    end
  end

  assign bus.ch2_on    = ch2_on_q;
  assign bus.duty_out  = duty_out_q;
  assign bus.duty_step = duty_step_q;
  assign bus.ch2_ftick = ch2_ftick_q;

endmodule

// File: tb/tb_ch2_tone_gen.sv
// tb_ch2_tone_gen
//   Vector table of per-cycle inputs and expected outputs, driven on the
//   falling edge; expected results go through a scoreboard queue and are
//   compared 1 time unit after the rising edge. Length expectations follow
//   whether CH2_LENGTH_EN is defined for the build.
module tb_ch2_tone_gen;
  import ch2_tone_gen_pkg::*;

`ifdef CH2_LENGTH_EN
  localparam bit LEN_ON = 1'b1;
`else
  localparam bit LEN_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic napu_reset;
  always #5 clk = ~clk;

  ch2_tone_gen_if bus ();

  ch2_tone_gen dut (
    .clk        (clk),
    .napu_reset (napu_reset),
    .bus        (bus)
  );

  // Patterns as written for step 0..7, leftmost character is step 0.
  localparam logic [7:0] REF_PAT [0:3] = '{
    8'b00000001, 8'b10000001, 8'b10000111, 8'b01111110
  };

  function automatic bit ref_level(logic [1:0] sel, logic [2:0] step);
    logic [7:0] p;
    p = REF_PAT[sel];
    return p[3'd7 - step];
  endfunction

  typedef struct {
    string       name;
    bit          rst, tf, tl, trig, lwr, len_en, dac;
    logic [1:0]  dsel;
    logic [5:0]  lload;
    logic [10:0] freq;
    bit          e_on;
    logic [2:0]  e_step;
    bit          e_ft;
  } vec_t;

  typedef struct {
    string      name;
    int         idx;
    bit         on, out, ft;
    logic [2:0] step;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Register-field values held across table entries.
  bit          c_len_en, c_dac;
  logic [1:0]  c_dsel;
  logic [5:0]  c_lload;
  logic [10:0] c_freq;

  function automatic void add(input string name, input bit rst, tf, tl, trig, lwr,
                              input bit e_on, input logic [2:0] e_step, input bit e_ft);
    vec_t v;
    v.name = name; v.rst = rst; v.tf = tf; v.tl = tl; v.trig = trig; v.lwr = lwr;
    v.len_en = c_len_en; v.dac = c_dac; v.dsel = c_dsel; v.lload = c_lload;
    v.freq = c_freq; v.e_on = e_on; v.e_step = e_step; v.e_ft = e_ft;
    tbl.push_back(v);
  endfunction

  task automatic check(input string what, input int idx,
                       input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", what, idx, act, req);
    end
  endtask

  initial begin
    exp_t e;

    napu_reset    = 1'b0;
    bus.tick_freq = 1'b0;
    bus.tick_len  = 1'b0;
    bus.duty_sel  = DUTY_12;
    bus.len_load  = '0;
    bus.len_wr    = 1'b0;
    bus.freq      = '0;
    bus.trig      = 1'b0;
    bus.len_en    = 1'b0;
    bus.dac_en    = 1'b0;

    // A: reset, then period of 2 ticks at freq=0x7FE
    c_dsel = 2'd0; c_freq = 11'h7FE; c_dac = 1'b1; c_len_en = 1'b0; c_lload = 6'd0;
    add("rst",      1, 0, 0, 0, 0, 0, 0, 0);
    add("rst_tf",   1, 1, 0, 0, 0, 0, 0, 0);
    add("trig",     0, 0, 0, 1, 0, 1, 0, 0);
    add("p2_t1",    0, 1, 0, 0, 0, 1, 0, 0);
    add("p2_t2",    0, 1, 0, 0, 0, 1, 1, 1);
    add("p2_t3",    0, 1, 0, 0, 0, 1, 1, 0);
    add("p2_t4",    0, 1, 0, 0, 0, 1, 2, 1);

    // B: 50 % pattern at one step per tick, trigger/tick collision, reload timing
    c_dsel = 2'd2; c_freq = 11'h7FF;
    add("rst",      1, 0, 0, 0, 0, 0, 0, 0);
    add("trig",     0, 0, 0, 1, 0, 1, 0, 0);
    for (int s = 1; s <= 8; s++) add("d50_tick", 0, 1, 0, 0, 0, 1, 3'(s), 1);
    add("idle",     0, 0, 0, 0, 0, 1, 0, 0);
    add("trig_tf",  0, 1, 0, 1, 0, 1, 0, 0);
    c_freq = 11'h7FE;
    add("reload_new", 0, 1, 0, 0, 0, 1, 1, 1);
    add("p2_a",     0, 1, 0, 0, 0, 1, 1, 0);
    add("p2_b",     0, 1, 0, 0, 0, 1, 2, 1);
    c_freq = 11'h000;
    add("mid_chg",  0, 1, 0, 0, 0, 1, 2, 0);
    add("old_per",  0, 1, 0, 0, 0, 1, 3, 1);

    // C: DAC gating
    c_freq = 11'h7FF;
    add("rst",      1, 0, 0, 0, 0, 0, 0, 0);
    c_dac = 1'b0;
    add("trig_nodac", 0, 0, 0, 1, 0, 0, 0, 0);
    add("idle_nodac", 0, 0, 0, 0, 0, 0, 0, 0);
    c_dac = 1'b1;
    add("trig_dac", 0, 0, 0, 1, 0, 1, 0, 0);
    c_dac = 1'b0;
    add("dac_drop", 0, 0, 0, 0, 0, 0, 0, 0);
    c_dac = 1'b1;
    add("dac_back", 0, 0, 0, 0, 0, 0, 0, 0);

    // D: length counter corners (dsel=2, step 0 => duty_out follows ch2_on)
    add("rst",      1, 0, 0, 0, 0, 0, 0, 0);
    c_len_en = 1'b1; c_lload = 6'd62;
    add("len_wr",   0, 0, 0, 0, 1, 0, 0, 0);
    add("trig",     0, 0, 0, 1, 0, 1, 0, 0);
    add("tl_1",     0, 0, 1, 0, 0, 1, 0, 0);
    add("tl_2",     0, 0, 1, 0, 0, !LEN_ON, 0, 0);
    add("idle_exp", 0, 0, 0, 0, 0, !LEN_ON, 0, 0);
    add("trig_tl",  0, 0, 1, 1, 0, 1, 0, 0);
    // lcnt must now be 1: 62 ticks reach 63, the 63rd wraps
    for (int i = 0; i < 62; i++) add("tl_run", 0, 0, 1, 0, 0, 1, 0, 0);
    add("tl_63",    0, 0, 1, 0, 0, !LEN_ON, 0, 0);
    c_lload = 6'd63;
    add("wr_tl",    0, 0, 1, 0, 1, !LEN_ON, 0, 0);
    add("trig",     0, 0, 0, 1, 0, 1, 0, 0);
    add("tl_wrap",  0, 0, 1, 0, 0, !LEN_ON, 0, 0);
    add("wr_trig",  0, 0, 0, 1, 1, 1, 0, 0);
    add("tl_wrap2", 0, 0, 1, 0, 0, !LEN_ON, 0, 0);
    c_len_en = 1'b0;
    add("trig_exp", 0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add("tl_off", 0, 0, 1, 0, 0, 1, 0, 0);

    // E: reset mid-period at ftmr=0x400, duty_step=5
    c_dsel = 2'd3; c_freq = 11'h7FF;
    add("rst",      1, 0, 0, 0, 0, 0, 0, 0);
    add("trig",     0, 0, 0, 1, 0, 1, 0, 0);
    for (int s = 1; s <= 4; s++) add("d75_tick", 0, 1, 0, 0, 0, 1, 3'(s), 1);
    c_freq = 11'h400;
    add("to_400",   0, 1, 0, 0, 0, 1, 5, 1);
    add("rst_mid",  1, 1, 0, 0, 0, 0, 0, 0);
    c_freq = 11'h7FE;
    add("re_trig",  0, 0, 0, 1, 0, 1, 0, 0);
    add("re_t1",    0, 1, 0, 0, 0, 1, 0, 0);
    add("re_t2",    0, 1, 0, 0, 0, 1, 1, 1);
    add("rst",      1, 0, 0, 0, 0, 0, 0, 0);
    c_freq = 11'h400;
    for (int i = 0; i < 2047; i++) add("from0", 0, 1, 0, 0, 0, 0, 0, 0);
    add("from0_wrap", 0, 1, 0, 0, 0, 0, 1, 1);

    foreach (tbl[i]) begin
      @(negedge clk);
      napu_reset    = !tbl[i].rst;
      bus.tick_freq = tbl[i].tf;
      bus.tick_len  = tbl[i].tl;
      bus.trig      = tbl[i].trig;
      bus.len_wr    = tbl[i].lwr;
      bus.len_en    = tbl[i].len_en;
      bus.dac_en    = tbl[i].dac;
      bus.duty_sel  = duty_sel_e'(tbl[i].dsel);
      bus.len_load  = tbl[i].lload;
      bus.freq      = tbl[i].freq;
      e.name = tbl[i].name;
      e.idx  = i;
      e.on   = tbl[i].e_on;
      e.step = tbl[i].e_step;
      e.ft   = tbl[i].e_ft;
      e.out  = tbl[i].e_on & ref_level(tbl[i].dsel, tbl[i].e_step);
      sb.push_back(e);

      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.name, ".ch2_on"},    e.idx, 32'(bus.ch2_on),    32'(e.on));
      check({e.name, ".duty_out"},  e.idx, 32'(bus.duty_out),  32'(e.out));
      check({e.name, ".duty_step"}, e.idx, 32'(bus.duty_step), 32'(e.step));
      check({e.name, ".ch2_ftick"}, e.idx, 32'(bus.ch2_ftick), 32'(e.ft));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ch2_tone_gen.md
# ch2_tone_gen

Channel 2 tone core: the consumer side of the channel 2 register file. It takes the latched NR21/NR23/NR24 fields and the write strobes, and produces the square-wave duty output and channel status. It runs the 11-bit frequency timer, the 8-step duty sequencer and the 6-bit length counter. It sits between the channel 2 register block and the envelope/mixer stage, in the single APU clock domain.

## Interface
Parameters:
- FREQ_W, 11, frequency timer width
- LEN_W, 6, length counter width

Ports:
- clk  in  1  APU clock
- napu_reset  in  1  reset, synchronous, active-low
- tick_freq  in  1  frequency timer clock enable, one clk wide
- tick_len  in  1  256 Hz length clock enable, one clk wide
- duty_sel  in  2  NR21[7:6]
- len_load  in  6  NR21[5:0]
- len_wr  in  1  NR21 write strobe, one clk
- freq  in  11  {NR24[2:0], NR23}
- trig  in  1  NR24 write with d7=1, one clk
- len_en  in  1  NR24[6]
- dac_en  in  1  NR22[7:3] != 0
- ch2_on  out  1  channel active (NR52 bit 1)
- duty_out  out  1  square wave level
- duty_step  out  3  current sequencer step
- ch2_ftick  out  1  timer overflow pulse, one clk

## Operation
- Frequency timer `ftmr` (11b) increments on tick_freq. On tick_freq with ftmr==0x7FF: reload ftmr=freq, pulse ch2_ftick, and step duty_step by +1 mod 8.
- freq changes take effect at the next reload only; no mid-period update.
- duty_out = pattern[duty_sel][duty_step], with pattern bits listed for step 0..7:
  - 0: 00000001
  - 1: 10000001
  - 2: 10000111
  - 3: 01111110
- duty_out is forced 0 while ch2_on=0.
- Length counter `lcnt` (6b, up-counting):
  - len_wr loads lcnt=len_load and clears the expired flag.
  - On tick_len with len_en=1 and not expired: lcnt+1. At the 63→0 wrap, set expired and clear ch2_on.
- Trigger (trig=1):
  - ftmr=freq; duty_step is unchanged.
  - If expired, then lcnt=0 and expired is cleared.
  - ch2_on=dac_en.
- dac_en=0 clears ch2_on in the same cycle and blocks enable by trigger.
- Simultaneous events:
  - trig with tick_freq: trigger wins, tick is dropped.
  - trig with tick_len: trigger reload applies first, then the tick counts if len_en=1 (lcnt=1 when the trigger reloaded from expired).
  - len_wr with tick_len: the load wins.
  - len_wr with trig: the load happens, then the trigger sees expired=0.

## Timing
- All outputs are registered; response is one clk after the qualifying input edge.
- Reset values (napu_reset=0 at a clk edge): ftmr=0, duty_step=0, lcnt=0, expired=0, ch2_on=0, duty_out=0, ch2_ftick=0.
- Reset asserted mid-period aborts all state within one edge; the first tick after release counts from ftmr=0.
- Period = (2048−freq) tick_freq pulses. freq=0x7FF gives ch2_ftick on every tick_freq.
- Length: 64−len_load tick_len pulses from a load to disable.

## Configuration
- CH2_LENGTH_EN defined: length counter, expired flag and len_en/tick_len/len_wr behaviour are present as above.
- CH2_LENGTH_EN undefined:
  - no length logic; lcnt is absent.
  - tick_len, len_wr, len_load and len_en are ignored.
  - ch2_on is cleared only by reset or dac_en=0.

## Structure
- Shared APU package holds:
  - duty pattern constant array DUTY_PAT[4] of 8 bits
  - FREQ_W/LEN_W defaults
  - duty_sel_e enum (DUTY_12, DUTY_25, DUTY_50, DUTY_75)
- One sub-module, `apu_len_ctr`: length counter plus expired flag, reused later by channels 1/3/4, parameterised on LEN_W.

## Test plan
- Reset, freq=0x7FE, trig, dac_en=1, tick_freq every cycle → ch2_ftick every 2nd tick; duty_step 0→1→2.
- duty_sel=2, freq=0x7FF, 8 ticks → duty_out sequence 1,0,0,0,0,1,1,1.
- len_load=62, len_en=1, trig, 2 tick_len → ch2_on falls exactly one clk after the 2nd tick.
- Expired channel, trig with tick_len in the same cycle → ch2_on=1, lcnt=1.
- dac_en=0 then trig → ch2_on stays 0 and duty_out=0; dac_en drop while on → ch2_on=0 next clk.
- napu_reset pulse mid-period at ftmr=0x400, duty_step=5 → all outputs 0; next trig restarts from freq with duty_step=0.
